// File: rtl/aes_sbox_share_checker_if.sv
// aes_sbox_share_checker_if: observation and result signals between the S-box checker and its environment.
interface aes_sbox_share_checker_if #(
  parameter int SHARES     = 2,
  parameter int NUM_CHECKS = 65536,
  parameter int CW         = $clog2(NUM_CHECKS + 1)
);
  logic                  StartxSI;
  logic                  InValidxSI;
  logic [8*SHARES-1:0]   _XxDI;
  logic [8*SHARES-1:0]   _QxDI;
  logic                  BusyxSO;
  logic                  DonexSO;
  logic                  PassxSO;
  logic                  ErrorxSO;
  logic [CW-1:0]         CheckCountxDO;
  logic [15:0]           ErrCountxDO;
  logic [7:0]            FirstErrInxDO;
  logic [7:0]            FirstErrExpxDO;
  logic [7:0]            FirstErrGotxDO;
  modport master (
    output StartxSI, InValidxSI, _XxDI, _QxDI,
    input  BusyxSO, DonexSO, PassxSO, ErrorxSO, CheckCountxDO, ErrCountxDO,
           FirstErrInxDO, FirstErrExpxDO, FirstErrGotxDO
  );
  modport slave (
    input  StartxSI, InValidxSI, _XxDI, _QxDI,
    output BusyxSO, DonexSO, PassxSO, ErrorxSO, CheckCountxDO, ErrCountxDO,
           FirstErrInxDO, FirstErrExpxDO, FirstErrGotxDO
  );
endinterface

// File: rtl/aes_sbox_share_checker.sv
// aes_sbox_share_checker: recombines masked S-box inputs/outputs and checks them against a reference SubBytes table.
module aes_sbox_share_checker #(
  parameter int SHARES     = 2,
  parameter int LATENCY    = 4,
  parameter int NUM_CHECKS = 65536
) (
  input logic                     ClkxCI,
  input logic                     RstxBI,
  aes_sbox_share_checker_if.slave bus
);
  localparam int CW = $clog2(NUM_CHECKS + 1);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e            state_q, state_d;
  logic [LATENCY-1:0] vld_q;
  logic [7:0]        x_q [LATENCY];
  logic [7:0]        e_q [LATENCY];
  logic [CW-1:0]     acc_q, acc_d, chk_q, chk_d;
  logic [15:0]       err_q, err_d;
  logic              error_q, error_d, busy_q, done_q;
  logic [7:0]        fin_q, fin_d, fexp_q, fexp_d, fgot_q, fgot_d;
  logic [7:0]        x_un, q_un;
  logic              start, accept, cmp, mism;
  always_comb begin
    x_un = '0;
    q_un = '0;
    for (int i = 0; i < SHARES; i++) begin
      x_un ^= bus._XxDI[8*i +: 8];
      q_un ^= bus._QxDI[8*i +: 8];
    end
  end
  assign start  = bus.StartxSI && (state_q == IDLE || state_q == DONE);
  assign accept = bus.InValidxSI && state_q == RUN && acc_q < CW'(NUM_CHECKS);
  assign cmp    = vld_q[LATENCY-1];
  assign mism   = cmp && e_q[LATENCY-1] != q_un;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    chk_d   = chk_q;
    err_d   = err_q;
    error_d = error_q;
    fin_d   = fin_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;
    if (start) begin
      state_d = RUN;
      acc_d   = '0;
      chk_d   = '0;
      err_d   = '0;
      error_d = 1'b0;
      fin_d   = '0;
      fexp_d  = '0;
      fgot_d  = '0;
    end else begin
      if (accept) begin
        acc_d = acc_q + 1'b1;
        if (acc_q == CW'(NUM_CHECKS - 1)) state_d = DRAIN;
      end
      if (state_q == DRAIN && vld_q == '0) state_d = DONE;
      if (cmp) chk_d = chk_q + 1'b1;
      if (mism) begin
        err_d   = &err_q ? err_q : err_q + 1'b1;
        error_d = 1'b1;
        fin_d   = error_q ? fin_q : x_q[LATENCY-1];
        fexp_d  = error_q ? fexp_q : e_q[LATENCY-1];
        fgot_d  = error_q ? fgot_q : q_un;
      end
    end
  end
  // Stage 0 captures the unmasked input and its reference value; no stall, so every stage shifts each cycle.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= IDLE;
      vld_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        x_q[i] <= '0;
        e_q[i] <= '0;
      end
      acc_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      error_q <= 1'b0;
      fin_q   <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q[0] <= accept;
      x_q[0]   <= x_un;
      e_q[0]   <= SBOX[x_un];
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        x_q[i]   <= x_q[i-1];
        e_q[i]   <= e_q[i-1];
      end
      acc_q   <= acc_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      error_q <= error_d;
      fin_q   <= fin_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
      busy_q  <= state_d == RUN || state_d == DRAIN;
      done_q  <= state_d == DONE;
    end
  end
  assign bus.BusyxSO        = busy_q;
  assign bus.DonexSO        = done_q;
  assign bus.PassxSO        = done_q && err_q == '0;
  assign bus.ErrorxSO       = error_q;
  assign bus.CheckCountxDO  = chk_q;
  assign bus.ErrCountxDO    = err_q;
  assign bus.FirstErrInxDO  = fin_q;
  assign bus.FirstErrExpxDO = fexp_q;
  assign bus.FirstErrGotxDO = fgot_q;
endmodule

// File: tb/tb_aes_sbox_share_checker.sv
// tb_aes_sbox_share_checker: drives a behavioural masked S-box and checks the checker against a queue-based model.
module tb_aes_sbox_share_checker;
  localparam int N  = 16;
  localparam int L  = 4;
  localparam int NS = 65537;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  aes_sbox_share_checker_if #(.SHARES(2), .NUM_CHECKS(N))  ifc ();
  aes_sbox_share_checker_if #(.SHARES(2), .NUM_CHECKS(NS)) ifs ();
  aes_sbox_share_checker #(.SHARES(2), .LATENCY(L), .NUM_CHECKS(N)) dut (
    .ClkxCI(clk), .RstxBI(rst_n), .bus(ifc.slave));
  aes_sbox_share_checker #(.SHARES(2), .LATENCY(L), .NUM_CHECKS(NS)) dus (
    .ClkxCI(clk), .RstxBI(rst_n), .bus(ifs.slave));
  typedef struct {logic v; logic [7:0] x; logic bad;} fl_t;
  typedef struct {
    int gap; int bad_x; int exp_chk; int exp_err; logic exp_pass;
    logic [7:0] fi; logic [7:0] fe; logic [7:0] fg; int lat;
  } vec_t;
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  logic [7:0] ref_sb [256];
  fl_t infl [$];
  logic [15:0] qq [$];
  int m_phase, m_acc, m_chk, m_err;
  logic m_erf;
  logic [7:0] m_fi, m_fe, m_fg;
  vec_t tbl [6];
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction
  // SubBytes from first principles: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_of(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic model_clear();
    m_acc = 0; m_chk = 0; m_err = 0; m_erf = 1'b0; m_fi = 8'h00; m_fe = 8'h00; m_fg = 8'h00;
  endtask
  task automatic model_reset();
    m_phase = 0;
    model_clear();
    infl.delete();
    repeat (L) infl.push_back(fl_t'{1'b0, 8'h00, 1'b0});
  endtask
  task automatic check_all(input string t);
    chk({t, ".busy"},  32'(ifc.BusyxSO),        32'(m_phase == 1 || m_phase == 2));
    chk({t, ".done"},  32'(ifc.DonexSO),        32'(m_phase == 3));
    chk({t, ".pass"},  32'(ifc.PassxSO),        32'(m_phase == 3 && m_err == 0));
    chk({t, ".error"}, 32'(ifc.ErrorxSO),       32'(m_erf));
    chk({t, ".chk"},   32'(ifc.CheckCountxDO),  32'(m_chk));
    chk({t, ".err"},   32'(ifc.ErrCountxDO),    32'(m_err));
    chk({t, ".fin"},   32'(ifc.FirstErrInxDO),  32'(m_fi));
    chk({t, ".fexp"},  32'(ifc.FirstErrExpxDO), 32'(m_fe));
    chk({t, ".fgot"},  32'(ifc.FirstErrGotxDO), 32'(m_fg));
  endtask
  // One clock of stimulus: the bench plays the masked S-box (outputs appear L edges after their input).
  task automatic cyc(input logic v, input logic [7:0] x, input logic bad, input logic st);
    logic [7:0] m, mo;
    logic acc, pre;
    int ph;
    fl_t f;
    m  = 8'($urandom);
    mo = 8'($urandom);
    ifc.StartxSI   = st;
    ifc.InValidxSI = v;
    ifc._XxDI      = {x ^ m, m};
    ifc._QxDI      = qq.pop_front();
    qq.push_back({ref_sb[x] ^ mo, mo ^ {7'd0, bad}});
    acc = v && m_phase == 1 && m_acc < N;
    pre = 1'b0;
    foreach (infl[i]) pre |= infl[i].v;
    infl.push_back(fl_t'{acc, x, bad});
    f  = infl.pop_front();
    ph = m_phase;
    @(posedge clk);
    cyc_n++;
    if (f.v) begin
      m_chk++;
      if (f.bad) begin
        if (m_err < 16'hffff) m_err++;
        if (!m_erf) begin
          m_fi = f.x; m_fe = ref_sb[f.x]; m_fg = ref_sb[f.x] ^ 8'h01;
        end
        m_erf = 1'b1;
      end
    end
    if (st && (ph == 0 || ph == 3)) begin
      model_clear();
      m_phase = 1;
    end else begin
      if (acc) begin
        m_acc++;
        if (m_acc == N) m_phase = 2;
      end
      if (ph == 2 && !pre) m_phase = 3;
    end
    #1 check_all("cyc");
  endtask
  task automatic run_row(input vec_t r, input int idx);
    int c1, lat;
    string nm;
    nm = $sformatf("row%0d", idx);
    c1 = 0;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int j = 0; j < N; j++) begin
      if (r.gap != 0) cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
      cyc(1'b1, 8'(j), j == r.bad_x, 1'b0);
      if (c1 == 0) c1 = cyc_n;
    end
    for (int w = 0; w < 60 && !ifc.DonexSO; w++) cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
    lat = ifc.DonexSO ? cyc_n - c1 + 1 : -1;
    chk({nm, ".lat"},  32'(lat),                  32'(r.lat));
    chk({nm, ".chk"},  32'(ifc.CheckCountxDO),    32'(r.exp_chk));
    chk({nm, ".err"},  32'(ifc.ErrCountxDO),      32'(r.exp_err));
    chk({nm, ".pass"}, 32'(ifc.PassxSO),          32'(r.exp_pass));
    chk({nm, ".error"}, 32'(ifc.ErrorxSO),        32'(!r.exp_pass));
    chk({nm, ".fin"},  32'(ifc.FirstErrInxDO),    32'(r.fi));
    chk({nm, ".fexp"}, 32'(ifc.FirstErrExpxDO),   32'(r.fe));
    chk({nm, ".fgot"}, 32'(ifc.FirstErrGotxDO),   32'(r.fg));
    repeat (2) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
  endtask
  initial begin
    tbl[0] = '{0, -1, 16, 0, 1'b1, 8'h00, 8'h00, 8'h00, 21};
    tbl[1] = '{0,  0, 16, 1, 1'b0, 8'h00, 8'h63, 8'h62, 21};
    tbl[2] = '{0,  5, 16, 1, 1'b0, 8'h05, 8'h6b, 8'h6a, 21};
    tbl[3] = '{1, -1, 16, 0, 1'b1, 8'h00, 8'h00, 8'h00, 36};
    tbl[4] = '{1, 15, 16, 1, 1'b0, 8'h0f, 8'h76, 8'h77, 36};
    tbl[5] = '{0, -1, 16, 0, 1'b1, 8'h00, 8'h00, 8'h00, 21};
    for (int i = 0; i < 256; i++) ref_sb[i] = sbox_of(8'(i));
    ifc.StartxSI = 1'b0; ifc.InValidxSI = 1'b0; ifc._XxDI = '0; ifc._QxDI = '0;
    ifs.StartxSI = 1'b0; ifs.InValidxSI = 1'b0; ifs._XxDI = '0; ifs._QxDI = '0;
    repeat (L) qq.push_back(16'h0000);
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cyc(k[0], 8'($urandom), 1'b0, 1'b0);
    chk("idle.chk", 32'(ifc.CheckCountxDO), 32'd0);
    for (int i = 0; i < 6; i++) run_row(tbl[i], i);
    // Abort a run with reset while data is in flight.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) cyc(1'b1, 8'(j), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 300 && m_phase != 3; k++)
        cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      chk("rand.done", 32'(ifc.DonexSO), 32'd1);
      for (int k = 0; k < 3; k++) cyc($urandom_range(0, 1) == 1, 8'($urandom), 1'b0, 1'b0);
    end
    // Saturation: every output wrong, first failing input differs from all later ones.
    ifc.StartxSI = 1'b0; ifc.InValidxSI = 1'b0;
    @(negedge clk) ifs.StartxSI = 1'b1;
    @(negedge clk) ifs.StartxSI = 1'b0;
    ifs.InValidxSI = 1'b1; ifs._XxDI = 16'h0001; ifs._QxDI = 16'h0000;
    @(negedge clk) ifs._XxDI = 16'h0000;
    repeat (NS - 1) @(negedge clk);
    ifs.InValidxSI = 1'b0;
    for (int w = 0; w < 30 && !ifs.DonexSO; w++) @(negedge clk);
    chk("sat.done",  32'(ifs.DonexSO),        32'd1);
    chk("sat.busy",  32'(ifs.BusyxSO),        32'd0);
    chk("sat.chk",   32'(ifs.CheckCountxDO),  32'(NS));
    chk("sat.err",   32'(ifs.ErrCountxDO),    32'h0000ffff);
    chk("sat.error", 32'(ifs.ErrorxSO),       32'd1);
    chk("sat.pass",  32'(ifs.PassxSO),        32'd0);
    chk("sat.fin",   32'(ifs.FirstErrInxDO),  32'h01);
    chk("sat.fexp",  32'(ifs.FirstErrExpxDO), 32'h7c);
    chk("sat.fgot",  32'(ifs.FirstErrGotxDO), 32'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
